// File: rtl/conv_pool_pkg.sv
// Shared types and helpers for the conv/pool engine: FSM state encoding, tap/quadrant counts,
// accumulator sizing and the ReLU-shift-saturate transfer function.
package conv_pool_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdwRd,
    StLdwCap,
    StTapRd,
    StTapAcc,
    StPool,
    StWr,
    StDone
  } state_e;

  localparam int unsigned NTAPS = 9;
  localparam int unsigned NQUAD = 4;

  // Unsigned pixel (DW+1 signed) times signed weight, summed over 9 taps.
  function automatic int unsigned acc_width(input int unsigned dw);
    return 2 * dw + 5;
  endfunction

  function automatic logic [31:0] sat_relu(input logic signed [63:0] acc,
                                           input int unsigned       shift,
                                           input int unsigned       dw);
    logic signed [63:0] s;
    logic signed [63:0] top;
    s   = acc >>> shift;
    top = (64'sd1 <<< dw) - 64'sd1;
    if (s < 0) return '0;
    if (s > top) return top[31:0];
    return s[31:0];
  endfunction

endpackage

// File: rtl/conv_pool_mac.sv
// Weight register file plus signed multiply-accumulate; presents the ReLU/saturated value of
// the current accumulator.
module conv_pool_mac
  import conv_pool_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned SHIFT = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          w_we_i,
  input  logic [3:0]    w_idx_i,
  input  logic [DW-1:0] w_data_i,
  input  logic          acc_en_i,
  input  logic          acc_clr_i,
  input  logic [DW-1:0] pix_i,
  input  logic [3:0]    tap_idx_i,
  output logic [DW-1:0] v_o
);

  localparam int unsigned AccW = acc_width(DW);
  localparam int unsigned PW   = 2 * DW + 1;

  logic signed [DW-1:0]   w_q [NTAPS];
  logic signed [DW-1:0]   w_d [NTAPS];
  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   w_sel;
  logic signed [PW-1:0]   prod;

  always_comb begin
    w_d = w_q;
    if (w_we_i) w_d[w_idx_i] = w_data_i;
    w_sel = w_q[tap_idx_i];
    // Pixel is zero-extended so it multiplies as a non-negative signed value.
    prod  = $signed(PW'({1'b0, pix_i})) * PW'(w_sel);
    acc_d = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + AccW'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q   <= '{default: '0};
      acc_q <= '0;
    end else begin
      w_q   <= w_d;
      acc_q <= acc_d;
    end
  end

  always_comb begin
    v_o = DW'(sat_relu(64'(acc_q), SHIFT, DW));
  end

endmodule

// File: rtl/conv_pool_engine.sv
// 3x3 valid convolution, ReLU/saturate and 2x2 stride-2 pooling over a shared single-port memory.
// Define CONV_POOL_AVG_EN for average pooling; max pooling otherwise.
module conv_pool_engine
  import conv_pool_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8,
  parameter int unsigned IN_BASE  = 1,
  parameter int unsigned W_BASE   = 65,
  parameter int unsigned OUT_BASE = 128,
  parameter int unsigned SHIFT    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          read,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned PO_W = (IMG_W - 2) / 2;
  localparam int unsigned PO_H = (IMG_H - 2) / 2;
  localparam int unsigned CW   = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H) + 1;
`ifdef CONV_POOL_AVG_EN
  localparam int unsigned PoolW = DW + 2;
`else
  localparam int unsigned PoolW = DW;
`endif

  state_e           state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic [1:0]       tx_q, tx_d, ty_q, ty_d;
  logic [1:0]       quad_q, quad_d;
  logic [CW-1:0]    px_q, px_d, py_q, py_d;
  logic [PoolW-1:0] pool_q, pool_d;
  logic [CW:0]      cy, cx;
  logic             w_we, acc_en, acc_clr;
  logic [3:0]       tap_idx;
  logic [DW-1:0]    v;

  // Quadrant bit 1 selects the conv row, bit 0 the conv column within the pool window.
  assign cy      = {py_q, quad_q[1]};
  assign cx      = {px_q, quad_q[0]};
  assign tap_idx = 4'(32'(ty_q) * 3 + 32'(tx_q));

  conv_pool_mac #(
    .DW   (DW),
    .SHIFT(SHIFT)
  ) u_mac (
    .clk_i    (clk),
    .rst_ni   (rst),
    .w_we_i   (w_we),
    .w_idx_i  (k_q),
    .w_data_i (mem_rdata),
    .acc_en_i (acc_en),
    .acc_clr_i(acc_clr),
    .pix_i    (mem_rdata),
    .tap_idx_i(tap_idx),
    .v_o      (v)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    quad_d    = quad_q;
    px_d      = px_q;
    py_d      = py_q;
    pool_d    = pool_q;
    read      = 1'b0;
    write     = 1'b0;
    addr      = '0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    w_we      = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy   = 1'b0;
        k_d    = '0;
        tx_d   = '0;
        ty_d   = '0;
        quad_d = '0;
        px_d   = '0;
        py_d   = '0;
        if (start) state_d = StLdwRd;
      end
      StLdwRd: begin
        read    = 1'b1;
        addr    = AW'(W_BASE + 32'(k_q));
        state_d = StLdwCap;
      end
      StLdwCap: begin
        w_we = 1'b1;
        if (k_q == 4'(NTAPS - 1)) begin
          k_d     = '0;
          state_d = StTapRd;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = StLdwRd;
        end
      end
      StTapRd: begin
        read    = 1'b1;
        addr    = AW'(IN_BASE + (32'(cy) + 32'(ty_q)) * IMG_W + 32'(cx) + 32'(tx_q));
        state_d = StTapAcc;
      end
      StTapAcc: begin
        acc_en  = 1'b1;
        state_d = StTapRd;
        if (tx_q == 2'd2) begin
          tx_d = '0;
          if (ty_q == 2'd2) begin
            ty_d    = '0;
            state_d = StPool;
          end else begin
            ty_d = ty_q + 2'd1;
          end
        end else begin
          tx_d = tx_q + 2'd1;
        end
      end
      StPool: begin
        acc_clr = 1'b1;
`ifdef CONV_POOL_AVG_EN
        pool_d = (quad_q == '0) ? PoolW'(v) : pool_q + PoolW'(v);
`else
        pool_d = (quad_q == '0 || v > pool_q) ? v : pool_q;
`endif
        if (quad_q == 2'(NQUAD - 1)) begin
          quad_d  = '0;
          state_d = StWr;
        end else begin
          quad_d  = quad_q + 2'd1;
          state_d = StTapRd;
        end
      end
      StWr: begin
        write = 1'b1;
        addr  = AW'(OUT_BASE + 32'(py_q) * PO_W + 32'(px_q));
`ifdef CONV_POOL_AVG_EN
        mem_wdata = pool_q[DW+1:2];
`else
        mem_wdata = pool_q;
`endif
        state_d = StTapRd;
        if (px_q == CW'(PO_W - 1)) begin
          px_d = '0;
          if (py_q == CW'(PO_H - 1)) begin
            py_d    = '0;
            state_d = StDone;
          end else begin
            py_d = py_q + CW'(1);
          end
        end else begin
          px_d = px_q + CW'(1);
        end
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      quad_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pool_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      quad_q  <= quad_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pool_q  <= pool_d;
    end
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Bench for conv_pool_engine: three instances (SHIFT 0, 2, 4) run in lockstep on private memories
// and are compared against an arithmetic model of convolution, ReLU/saturate and pooling.
`timescale 1ns/1ps
module tb_conv_pool_engine;

  localparam int NDUT     = 3;
  localparam int IW       = 8;
  localparam int PW       = 3;
  localparam int NOUT     = 9;
  localparam int IN_BASE  = 1;
  localparam int W_BASE   = 65;
  localparam int OUT_BASE = 128;
  localparam int LATENCY  = 712;
  localparam logic [7:0] SENT = 8'hA5;

  typedef struct {
    int    img;
    int    wk;
    int    e0;
    int    e2;
    int    e4;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic load = 1'b0;
  logic clr = 1'b0;
  logic [7:0] src [256];
  logic [7:0] peek_addr = 8'd0;
  int pix [IW][IW];
  int wt [9];
  int vectors = 0;
  int miscompares = 0;

  logic [NDUT-1:0]       rd_v, wr_v, busy_v, done_v, clash_v, abad_v, ibad_v;
  logic [NDUT-1:0][7:0]  addr_v, peek_v;
  logic [NDUT-1:0][15:0] wcnt_v, dcnt_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic rd, wr, busy, done;
    logic [7:0] addr, wdata, rdq;
    logic [7:0] mem [256];
    logic [15:0] wcnt, dcnt;
    logic clash, abad, ibad;

    conv_pool_engine #(.SHIFT(2 * g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .read     (rd),
      .write    (wr),
      .addr     (addr),
      .mem_wdata(wdata),
      .mem_rdata(rdq)
    );

    always @(posedge clk) begin
      if (load) begin
        for (int a = 0; a < 256; a++) mem[a] <= src[a];
      end else if (wr) begin
        mem[addr] <= wdata;
      end
      if (rd) rdq <= mem[addr];
      if (clr) begin
        wcnt <= 0; dcnt <= 0; clash <= 0; abad <= 0; ibad <= 0;
      end else begin
        if (wr) begin
          wcnt <= wcnt + 16'd1;
          if (addr != 8'(OUT_BASE + int'(wcnt))) abad <= 1'b1;
        end
        if (done) dcnt <= dcnt + 16'd1;
        if (rd && wr) clash <= 1'b1;
        if (!rd && !wr && addr != 8'd0) ibad <= 1'b1;
      end
    end

    assign rd_v[g]    = rd;
    assign wr_v[g]    = wr;
    assign busy_v[g]  = busy;
    assign done_v[g]  = done;
    assign addr_v[g]  = addr;
    assign peek_v[g]  = mem[peek_addr];
    assign wcnt_v[g]  = wcnt;
    assign dcnt_v[g]  = dcnt;
    assign clash_v[g] = clash;
    assign abad_v[g]  = abad;
    assign ibad_v[g]  = ibad;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int img, input int wk);
    for (int a = 0; a < 256; a++) src[a] = 8'h00;
    for (int y = 0; y < IW; y++) begin
      for (int x = 0; x < IW; x++) begin
        case (img)
          0:       pix[y][x] = 8 * y + x + 1;
          1:       pix[y][x] = 255;
          2:       pix[y][x] = 1;
          default: pix[y][x] = int'($urandom_range(0, 255));
        endcase
        src[IN_BASE + y * IW + x] = 8'(pix[y][x]);
      end
    end
    for (int k = 0; k < 9; k++) begin
      case (wk)
        0:       wt[k] = (k == 4) ? 1 : 0;
        1:       wt[k] = -1;
        2:       wt[k] = 127;
        3:       wt[k] = 1;
        default: wt[k] = int'($urandom_range(0, 255)) - 128;
      endcase
      src[W_BASE + k] = 8'(wt[k]);
    end
    for (int i = 0; i < NOUT; i++) src[OUT_BASE + i] = SENT;
  endtask

  // Pooled output straight from the definitions, for a given shift.
  function automatic int model(input int py, input int px, input int sh);
    int acc, v, res;
    res = 0;
    for (int q = 0; q < 4; q++) begin
      acc = 0;
      for (int ty = 0; ty < 3; ty++)
        for (int tx = 0; tx < 3; tx++)
          acc += pix[2 * py + q / 2 + ty][2 * px + q % 2 + tx] * wt[ty * 3 + tx];
      acc = acc >>> sh;
      v = (acc < 0) ? 0 : (acc > 255) ? 255 : acc;
`ifdef CONV_POOL_AVG_EN
      res += v;
`else
      if (v > res) res = v;
`endif
    end
`ifdef CONV_POOL_AVG_EN
    res = res / 4;
`endif
    return res;
  endfunction

  task automatic do_load();
    @(negedge clk); load = 1'b1; clr = 1'b1;
    @(negedge clk); load = 1'b0; clr = 1'b0;
  endtask

  task automatic peek(input int a, input int d, output int val);
    peek_addr = 8'(a);
    #1;
    val = int'(peek_v[d]);
  endtask

  // Runs a job; optionally re-pulses start at cycle repulse_at or drops reset at cycle abort_at.
  task automatic run_job(input int repulse_at, input int abort_at, output int lat);
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        chk("busy_after_start", busy_v, {NDUT{1'b1}});
      end
      if (lat == repulse_at) start = 1'b1;
      if (lat == repulse_at + 1) start = 1'b0;
      if (lat == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_read", rd_v, 0);
        chk("abort_write", wr_v, 0);
        chk("abort_busy", busy_v, 0);
        chk("abort_addr", addr_v, 0);
        return;
      end
      if (done_v[0]) break;
      if (lat > 2000) begin
        chk("done_timeout", 0, 1);
        return;
      end
    end
    chk("done_all", done_v, {NDUT{1'b1}});
    chk("busy_at_done", busy_v, 0);
    @(posedge clk); #1;
    chk("done_pulse_end", done_v, 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag);
    int val;
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < NOUT; i++) begin
        peek(OUT_BASE + i, d, val);
        chk($sformatf("%s dut%0d out%0d", tag, d, i), val, model(i / PW, i % PW, 2 * d));
      end
      chk($sformatf("%s dut%0d writes", tag, d), wcnt_v[d], NOUT);
      chk($sformatf("%s dut%0d dones", tag, d), dcnt_v[d], 1);
      chk($sformatf("%s dut%0d rw_clash", tag, d), clash_v[d], 0);
      chk($sformatf("%s dut%0d wr_addr", tag, d), abad_v[d], 0);
      chk($sformatf("%s dut%0d idle_addr", tag, d), ibad_v[d], 0);
    end
  endtask

  initial begin
    vec_t tbl [8];
    int lat, val;

`ifdef CONV_POOL_AVG_EN
    tbl[0] = '{img: 0, wk: 0, e0: 14, e2: 3, e4: 0, name: "identity_ramp"};
`else
    tbl[0] = '{img: 0, wk: 0, e0: 19, e2: 4, e4: 1, name: "identity_ramp"};
`endif
    tbl[1] = '{img: 0, wk: 1, e0: 0, e2: 0, e4: 0, name: "neg_ramp"};
    tbl[2] = '{img: 3, wk: 1, e0: 0, e2: 0, e4: 0, name: "neg_rand"};
    tbl[3] = '{img: 1, wk: 2, e0: 255, e2: 255, e4: 255, name: "saturate"};
    tbl[4] = '{img: 2, wk: 3, e0: 9, e2: 2, e4: 0, name: "ones"};
    tbl[5] = '{img: 3, wk: 4, e0: -1, e2: -1, e4: -1, name: "rand_a"};
    tbl[6] = '{img: 3, wk: 4, e0: -1, e2: -1, e4: -1, name: "rand_b"};
    tbl[7] = '{img: 3, wk: 4, e0: -1, e2: -1, e4: -1, name: "rand_c"};

    #2 rst = 1'b0;
    #1;
    chk("reset_busy", busy_v, 0);
    chk("reset_done", done_v, 0);
    chk("reset_read", rd_v, 0);
    chk("reset_write", wr_v, 0);
    chk("reset_addr", addr_v, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].img, tbl[i].wk);
      do_load();
      run_job(-1, -1, lat);
      chk({tbl[i].name, " latency"}, lat, LATENCY);
      check_results(tbl[i].name);
      if (tbl[i].e0 >= 0) begin
        peek(OUT_BASE, 0, val);
        chk({tbl[i].name, " s0 out00"}, val, tbl[i].e0);
        peek(OUT_BASE, 1, val);
        chk({tbl[i].name, " s2 out00"}, val, tbl[i].e2);
        peek(OUT_BASE, 2, val);
        chk({tbl[i].name, " s4 out00"}, val, tbl[i].e4);
      end
    end

    // A second start while busy must not restart or add a done pulse.
    fill(0, 0);
    do_load();
    run_job(50, -1, lat);
    chk("repulse latency", lat, LATENCY);
    check_results("repulse");
    peek(OUT_BASE + 1, 0, val);
`ifdef CONV_POOL_AVG_EN
    chk("identity out01", val, 16);
    peek(OUT_BASE + 8, 0, val);
    chk("identity out22", val, 50);
`else
    chk("identity out01", val, 21);
    peek(OUT_BASE + 8, 0, val);
    chk("identity out22", val, 55);
`endif

    // Reset mid-run: three outputs already landed (cycles 95, 172, 249), the fourth never does.
    fill(3, 4);
    do_load();
    run_job(-1, 300, lat);
    for (int i = 0; i < 4; i++) begin
      peek(OUT_BASE + i, 0, val);
      chk($sformatf("partial out%0d", i), val, (i < 3) ? model(0, i, 0) : int'(SENT));
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    run_job(-1, -1, lat);
    chk("after_reset latency", lat, LATENCY);
    check_results("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_pool_engine.md
Name: conv_pool_engine

Overview:
- Parametrised successor to the fixed 8x8 conv/pool block.
- Reads an IMG_H x IMG_W unsigned image and a 3x3 signed kernel from a single-port synchronous memory.
- Computes a valid 3x3 convolution, then ReLU with shift and saturate, then 2x2 stride-2 max pooling.
- Writes the pooled map back to the same memory; adds a start/busy/done handshake.

Parameters:
- DW, 8, pixel, weight and output data width
- AW, 8, memory address width
- IMG_W, 8, image width in pixels (>=4)
- IMG_H, 8, image height in pixels (>=4)
- IN_BASE, 1, address of pixel (0,0); image stored row-major
- W_BASE, 65, address of weight (0,0); 9 signed weights stored row-major
- OUT_BASE, 128, address of pooled output (0,0); stored row-major
- SHIFT, 0, arithmetic right shift applied to the accumulator before ReLU/saturate

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when the last output has been written
- read  out  1  memory read strobe
- write  out  1  memory write strobe
- addr  out  AW  memory address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid the cycle after read is high

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. read, write, busy and done are 0; addr and mem_wdata are 0; all counters and the accumulator are cleared. Any job in progress is abandoned; partially written outputs remain in memory.
- Output grid: PO_W=floor((IMG_W-2)/2), PO_H=floor((IMG_H-2)/2). An odd trailing conv row or column is dropped.
- Addressing: pixel(y,x) is at IN_BASE+y*IMG_W+x. Weight k is at W_BASE+k. Output(py,px) is at OUT_BASE+py*PO_W+px.
- FSM states: IDLE, LDW_RD, LDW_CAP, TAP_RD, TAP_ACC, POOL, WR, DONE.
  - IDLE: start=1 -> LDW_RD. start in any other state is ignored.
  - LDW_RD: read=1, addr=W_BASE+k. Next state LDW_CAP captures mem_rdata into weight[k]. After k=8 -> TAP_RD, otherwise -> LDW_RD.
  - TAP_RD: read=1, addr=pixel(cy+ty, cx+tx). Next state TAP_ACC does acc += zero-extended pixel * signed weight. After the 9th tap -> POOL, otherwise -> TAP_RD.
  - POOL: v = sat(relu(acc>>>SHIFT)) to [0, 2^DW-1]. pool = (first quadrant ? v : max(pool,v)). acc is cleared. Quadrant order: (0,0),(0,1),(1,0),(1,1). After the 4th quadrant -> WR, otherwise -> TAP_RD.
  - WR: write=1, addr=output address, mem_wdata=pool. After the last output -> DONE, otherwise -> TAP_RD for the next pool cell, row-major.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Strobes: read and write are never high together. addr is held only while a strobe is high and is 0 otherwise.
- Accumulator: signed, ACC_W = 2*DW+5 bits, so it never overflows.
- Latency from start to done: 1 + 18 + PO_W*PO_H*(4*19+1) cycles. With the defaults this is 712 cycles (done high in cycle 712 after start).

Optional Feature:
- Macro CONV_POOL_AVG_EN.
- Defined: pooling is the average of the 4 clipped values, i.e. (sum of 4) >> 2, truncating, using a DW+2-bit sum.
- Undefined: max pooling.
- Cycle timing is identical in both modes.

Decomposition:
- Package conv_pool_pkg holds:
  - state enum
  - NTAPS=9 and NQUAD=4
  - function acc_width(DW)
  - function sat_relu(acc, SHIFT, DW)
- Sub-module conv_pool_mac holds the weight register file, the signed MAC, the clear/accumulate controls and the ReLU/saturate output.
- The FSM, address generation and pooling stay in conv_pool_engine.

Test Plan:
- Identity kernel (centre weight 1, others 0, SHIFT=0), pixel(y,x)=8y+x+1 -> out(0,0)=19, out(0,1)=21, out(2,2)=55; 9 writes to addresses 128..136; done after 712 cycles.
- All weights -1, any image -> all 9 outputs 0 (ReLU).
- All weights 127, all pixels 255 -> all outputs 255 (saturation). Same case with SHIFT=4 -> still 255. All pixels 1 with weights 1 and SHIFT=2 -> 9>>2=2.
- CONV_POOL_AVG_EN defined, identity kernel, ramp image -> out(0,0)=(10+11+18+19)>>2=14.
- start pulsed again at cycle 50 of a busy run -> ignored; exactly one done pulse; results unchanged.
- rst dropped at cycle 300 of a run -> read, write and busy go to 0 immediately. Releasing reset and pulsing start gives correct results with full latency.
